// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-channel arbiters.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    RELAY      = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    jj      = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!found_o && req_i[jj]) begin
        found_o = 1'b1;
        idx_o   = jj;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Starvation-free round-robin arbiter sharing one valid/ready memory channel
// between NUM_CONSUMERS requesters; every output is registered.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int ADDR_BITS     = 8,
  parameter  int DATA_BITS     = 8,
  parameter  int NUM_CONSUMERS = 4,
  parameter  int WRITE_ENABLE  = 1,
  localparam int ID_W          = $clog2(NUM_CONSUMERS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
  input  logic [ADDR_BITS-1:0]     consumer_read_address  [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
  output logic [DATA_BITS-1:0]     consumer_read_data     [NUM_CONSUMERS],
  input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
  input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
  input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
  output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
  output logic                     mem_read_valid,
  output logic [ADDR_BITS-1:0]     mem_read_address,
  input  logic                     mem_read_ready,
  input  logic [DATA_BITS-1:0]     mem_read_data,
  output logic                     mem_write_valid,
  output logic [ADDR_BITS-1:0]     mem_write_address,
  output logic [DATA_BITS-1:0]     mem_write_data,
  input  logic                     mem_write_ready,
  output logic [ID_W-1:0]          grant_id
);

  arb_state_t               state_q, state_d;
  logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]          grant_q, grant_d;
  logic                     mem_rv_q, mem_rv_d;
  logic                     mem_wv_q, mem_wv_d;
  logic [ADDR_BITS-1:0]     rd_addr_q, rd_addr_d;
  logic [ADDR_BITS-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_BITS-1:0]     wr_data_q, wr_data_d;
  logic [NUM_CONSUMERS-1:0] crd_q, crd_d;
  logic [NUM_CONSUMERS-1:0] cwr_q, cwr_d;
  logic                     relay_wr_q, relay_wr_d;
  logic [DATA_BITS-1:0]     rdata_q [NUM_CONSUMERS];
  logic                     rdata_we;

  logic [NUM_CONSUMERS-1:0] wr_req;
  logic [NUM_CONSUMERS-1:0] req;
  logic                     pick_found;
  logic [ID_W-1:0]          pick_idx;
  logic                     relay_valid;

  assign wr_req = (WRITE_ENABLE != 0) ? consumer_write_valid : '0;
  assign req    = consumer_read_valid | wr_req;

  rr_pick #(
    .N  (NUM_CONSUMERS),
    .IW (ID_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // RELAY waits on whichever valid the completed transaction belonged to
  assign relay_valid = relay_wr_q ? wr_req[grant_q] : consumer_read_valid[grant_q];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    mem_rv_d   = mem_rv_q;
    mem_wv_d   = mem_wv_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    crd_d      = crd_q;
    cwr_d      = cwr_q;
    relay_wr_d = relay_wr_q;
    rdata_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          if (consumer_read_valid[pick_idx]) begin
            mem_rv_d  = 1'b1;
            rd_addr_d = consumer_read_address[pick_idx];
            state_d   = READ_WAIT;
          end else begin
            mem_wv_d  = 1'b1;
            wr_addr_d = consumer_write_address[pick_idx];
            wr_data_d = consumer_write_data[pick_idx];
            state_d   = WRITE_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_read_ready) begin
          mem_rv_d       = 1'b0;
          rdata_we       = 1'b1;
          crd_d[grant_q] = 1'b1;
          relay_wr_d     = 1'b0;
          state_d        = RELAY;
        end
      end
      WRITE_WAIT: begin
        if (mem_write_ready) begin
          mem_wv_d       = 1'b0;
          cwr_d[grant_q] = 1'b1;
          relay_wr_d     = 1'b1;
          state_d        = RELAY;
        end
      end
      RELAY: begin
        if (!relay_valid) begin
          crd_d    = '0;
          cwr_d    = '0;
          rr_ptr_d = (grant_q == ID_W'(NUM_CONSUMERS - 1)) ? '0 : grant_q + 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      mem_rv_q   <= 1'b0;
      mem_wv_q   <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      crd_q      <= '0;
      cwr_q      <= '0;
      relay_wr_q <= 1'b0;
      for (int k = 0; k < NUM_CONSUMERS; k++) rdata_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      mem_rv_q   <= mem_rv_d;
      mem_wv_q   <= mem_wv_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      relay_wr_q <= relay_wr_d;
      if (rdata_we) rdata_q[grant_q] <= mem_read_data;
    end
  end

  assign mem_read_valid       = mem_rv_q;
  assign mem_read_address     = rd_addr_q;
  assign mem_write_valid      = (WRITE_ENABLE != 0) ? mem_wv_q  : 1'b0;
  assign mem_write_address    = (WRITE_ENABLE != 0) ? wr_addr_q : '0;
  assign mem_write_data       = (WRITE_ENABLE != 0) ? wr_data_q : '0;
  assign consumer_write_ready = (WRITE_ENABLE != 0) ? cwr_q     : '0;
  assign consumer_read_ready  = crd_q;
  assign consumer_read_data   = rdata_q;
  assign grant_id             = grant_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: memory model, consumer agent with scoreboard, vector table.
module tb_mem_rr_arbiter;
  localparam int N  = 4;
  localparam int AB = 8;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [N-1:0]  crv, cwv, crr, cwr;
  logic [AB-1:0] cra [N];
  logic [AB-1:0] cwa [N];
  logic [DB-1:0] cwd [N];
  logic [DB-1:0] crd [N];
  logic          mrv, mrr, mwv, mwr;
  logic [AB-1:0] mra, mwa;
  logic [DB-1:0] mrd, mwd;
  logic [1:0]    gid;

  logic [N-1:0]  r_crv, r_cwv, r_crr, r_cwr;
  logic [AB-1:0] r_cra [N];
  logic [AB-1:0] r_cwa [N];
  logic [DB-1:0] r_cwd [N];
  logic [DB-1:0] r_crd [N];
  logic          r_mrv, r_mrr, r_mwv, r_mwr;
  logic [AB-1:0] r_mra, r_mwa;
  logic [DB-1:0] r_mrd, r_mwd;
  logic [1:0]    r_gid;

  mem_rr_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N), .WRITE_ENABLE(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .consumer_read_valid(crv), .consumer_read_address(cra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(cwv), .consumer_write_address(cwa),
    .consumer_write_data(cwd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra), .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa), .mem_write_data(mwd),
    .mem_write_ready(mwr), .grant_id(gid));

  mem_rr_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CONSUMERS(N), .WRITE_ENABLE(0)) dut_ro (
    .clk(clk), .reset_n(reset_n),
    .consumer_read_valid(r_crv), .consumer_read_address(r_cra),
    .consumer_read_ready(r_crr), .consumer_read_data(r_crd),
    .consumer_write_valid(r_cwv), .consumer_write_address(r_cwa),
    .consumer_write_data(r_cwd), .consumer_write_ready(r_cwr),
    .mem_read_valid(r_mrv), .mem_read_address(r_mra), .mem_read_ready(r_mrr), .mem_read_data(r_mrd),
    .mem_write_valid(r_mwv), .mem_write_address(r_mwa), .mem_write_data(r_mwd),
    .mem_write_ready(r_mwr), .grant_id(r_gid));

  typedef struct {int k; logic [7:0] data;} rd_exp_t;
  typedef struct {logic [7:0] addr; logic [7:0] data;} wr_exp_t;
  typedef struct {
    int k; bit wr; logic [7:0] addr; logic [7:0] wdata;
    int lat; int exp_cyc; logic [7:0] exp_rdata;
  } vec_t;

  rd_exp_t rd_sb[$];
  wr_exp_t wr_sb[$];
  int      opq[$];
  int      lat;
  int      rd_rep [N];
  bit      reraise [N];
  int      tests = 0;
  int      fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: ready after 'lat' idle cycles, read data = addr + 0x90
  initial begin
    int      rc;
    int      wc;
    wr_exp_t we;
    rc = 0; wc = 0;
    mrr = 1'b0; mwr = 1'b0; mrd = '0;
    forever begin
      @(negedge clk);
      if (mrr) begin
        mrr = 1'b0; rc = 0;
      end else if (mrv) begin
        if (rc >= lat) begin
          mrr = 1'b1; mrd = mra + 8'h90; rc = 0; opq.push_back(0);
        end else rc++;
      end else rc = 0;
      if (mwr) begin
        mwr = 1'b0; wc = 0;
      end else if (mwv) begin
        if (wc >= lat) begin
          mwr = 1'b1; wc = 0; opq.push_back(1);
          if (wr_sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL wr_unexpected: got write addr %0h, none expected", mwa);
          end else begin
            we = wr_sb.pop_front();
            check("wr_addr", mwa, we.addr);
            check("wr_data", mwd, we.data);
          end
        end else wc++;
      end else wc = 0;
    end
  end

  // Consumer agent: completes handshakes and scores returned read data
  initial begin
    rd_exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (crr[k] && crv[k]) begin
          if (rd_sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL rd_unexpected: got read on consumer %0d, none expected", k);
          end else begin
            e = rd_sb.pop_front();
            check("rd_consumer", k, e.k);
            check("rd_data", crd[k], e.data);
          end
          crv[k] = 1'b0;
          if (rd_rep[k] > 0) begin
            rd_rep[k]--;
            reraise[k] = 1'b1;
          end
        end else if (reraise[k]) begin
          crv[k] = 1'b1;
          reraise[k] = 1'b0;
        end
        if (cwr[k] && cwv[k]) cwv[k] = 1'b0;
      end
    end
  end

  task automatic wait_idle(input int bound, input string name);
    int c = 0;
    while (c < bound && !(rd_sb.size() == 0 && wr_sb.size() == 0 && !mrv && !mwv
                          && crr == '0 && cwr == '0)) begin
      @(negedge clk);
      c++;
    end
    check(name, (c < bound), 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vec_t tbl [6];
    int   cyc;
    int   c;
    bit   seen_wv, seen_cwr, got;
    logic [7:0] gotdata;

    tbl[0] = '{1, 1'b0, 8'h33, 8'h00, 0, 2, 8'hC3};
    tbl[1] = '{2, 1'b0, 8'hFF, 8'h00, 1, 3, 8'h8F};
    tbl[2] = '{3, 1'b0, 8'h00, 8'h00, 3, 5, 8'h90};
    tbl[3] = '{0, 1'b1, 8'h44, 8'hC6, 0, 2, 8'h00};
    tbl[4] = '{2, 1'b1, 8'hEE, 8'h01, 2, 4, 8'h00};
    tbl[5] = '{0, 1'b0, 8'h70, 8'h00, 0, 2, 8'h00};

    reset_n = 1'b0;
    lat = 0;
    crv = '0; cwv = '0;
    r_crv = '0; r_cwv = '0; r_mrr = 1'b0; r_mwr = 1'b0; r_mrd = '0;
    for (int k = 0; k < N; k++) begin
      cra[k] = 8'(8'h10 + k); cwa[k] = '0; cwd[k] = '0;
      r_cra[k] = 8'h05; r_cwa[k] = 8'h06; r_cwd[k] = '0;
      rd_rep[k] = 0; reraise[k] = 1'b0;
    end

    // Reset held with everyone requesting
    crv = '1;
    repeat (3) @(negedge clk);
    check("rst_mem_read_valid", mrv, 0);
    check("rst_mem_write_valid", mwv, 0);
    check("rst_grant_id", gid, 0);
    check("rst_read_ready", crr, 0);
    check("rst_write_ready", cwr, 0);
    check("rst_mem_read_address", mra, 0);
    check("rst_read_data0", crd[0], 0);

    // Release: service order 0,1,2,3 with 2-cycle memory
    lat = 2;
    for (int k = 0; k < N; k++) rd_sb.push_back('{k, 8'(8'hA0 + k)});
    reset_n = 1'b1;
    @(negedge clk);
    check("first_grant_id", gid, 0);
    check("first_mem_read_valid", mrv, 1);
    check("first_mem_read_address", mra, 8'h10);
    wait_idle(200, "all4_done");

    // Vector table: single transactions, latency from request to ready
    for (int i = 0; i < 6; i++) begin
      lat = tbl[i].lat;
      if (tbl[i].wr) begin
        cwa[tbl[i].k] = tbl[i].addr;
        cwd[tbl[i].k] = tbl[i].wdata;
        wr_sb.push_back('{tbl[i].addr, tbl[i].wdata});
        cwv[tbl[i].k] = 1'b1;
      end else begin
        cra[tbl[i].k] = tbl[i].addr;
        rd_sb.push_back('{tbl[i].k, tbl[i].exp_rdata});
        crv[tbl[i].k] = 1'b1;
      end
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!(tbl[i].wr ? cwr[tbl[i].k] : crr[tbl[i].k]) && cyc < 50);
      check($sformatf("tbl%0d_latency", i), cyc, tbl[i].exp_cyc);
      check($sformatf("tbl%0d_grant", i), gid, tbl[i].k);
      wait_idle(100, $sformatf("tbl%0d_done", i));
    end
    for (int k = 0; k < N; k++) cra[k] = 8'(8'h10 + k);

    // Consumer 3 read and write together: read first
    lat = 0;
    opq.delete();
    cra[3] = 8'h20; cwa[3] = 8'h20; cwd[3] = 8'h5A;
    rd_sb.push_back('{3, 8'hB0});
    wr_sb.push_back('{8'h20, 8'h5A});
    crv[3] = 1'b1; cwv[3] = 1'b1;
    wait_idle(100, "rw_done");
    check("rw_op_count", opq.size(), 2);
    if (opq.size() == 2) begin
      check("rw_first_is_read", opq[0], 0);
      check("rw_second_is_write", opq[1], 1);
    end

    // Consumer 2 requests back-to-back; consumer 1 must get in between
    lat = 1;
    cra[3] = 8'h13;
    rd_rep[2] = 1;
    rd_sb.push_back('{2, 8'hA2});
    rd_sb.push_back('{1, 8'hA1});
    rd_sb.push_back('{2, 8'hA2});
    crv[2] = 1'b1;
    c = 0;
    while (!mrv && c < 20) begin @(negedge clk); c++; end
    check("cont_first_grant_seen", mrv, 1);
    crv[1] = 1'b1;
    wait_idle(200, "cont_done");

    // Asynchronous reset during READ_WAIT
    lat = 20;
    crv[1] = 1'b1;
    c = 0;
    while (!mrv && c < 20) begin @(negedge clk); c++; end
    check("abort_grant_seen", mrv, 1);
    check("abort_grant_id", gid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_mem_read_valid", mrv, 0);
    check("abort_grant_id_cleared", gid, 0);
    crv[1] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    lat = 0;
    rd_sb.push_back('{0, 8'hA0});
    rd_sb.push_back('{3, 8'hA3});
    crv[0] = 1'b1; crv[3] = 1'b1;
    wait_idle(100, "post_reset_done");
    check("held_read_data0", crd[0], 8'hA0);
    check("held_read_data3", crd[3], 8'hA3);

    // Read-only instance: writes ignored, reads still served
    r_mrr = 1'b1; r_mwr = 1'b1; r_mrd = 8'h77; r_cwd[0] = 8'h3C;
    r_cwv[0] = 1'b1; r_crv[1] = 1'b1;
    seen_wv = 1'b0; seen_cwr = 1'b0; got = 1'b0; gotdata = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (r_mwv) seen_wv = 1'b1;
      if (r_cwr != '0) seen_cwr = 1'b1;
      if (r_crr[1] && r_crv[1]) begin
        got = 1'b1; gotdata = r_crd[1]; r_crv[1] = 1'b0;
      end
    end
    check("ro_mem_write_valid", seen_wv, 0);
    check("ro_write_ready", seen_cwr, 0);
    check("ro_read_served", got, 1);
    check("ro_read_data", gotdata, 8'h77);
    check("ro_grant_id", r_gid, 1);
    check("ro_mem_write_address", r_mwa, 0);
    check("ro_mem_write_data", r_mwd, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
